// File: rtl/vram_line_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vram_line_scheduler_pkg
// Purpose  : Shared video definitions: VGA 640x480@60 timing constants,
//            default VRAM geometry and the line-scheduler state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vram_line_scheduler_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int c_h_visible = 640;
  localparam int c_h_front   = 16;
  localparam int c_h_sync    = 96;
  localparam int c_h_back    = 48;
  localparam int c_h_total   = c_h_visible + c_h_front + c_h_sync + c_h_back;

  // Vertical timing, in lines.
  localparam int c_v_visible = 480;
  localparam int c_v_front   = 10;
  localparam int c_v_sync    = 2;
  localparam int c_v_back    = 33;
  localparam int c_v_total   = c_v_visible + c_v_front + c_v_sync + c_v_back;

  // Default VRAM geometry.
  localparam int c_default_addr_w = 16;
  localparam int c_default_data_w = 16;

  // Scheduler states: IDLE serves the CPU, FETCH issues line reads,
  // DRAIN waits for the last read word to land in the line buffer.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage : vram_line_scheduler_pkg
`default_nettype wire

// File: rtl/vram_line_scheduler_read_tracker.sv
`default_nettype none
// ============================================================================
// Module   : vram_read_tracker
// Purpose  : One-deep tag for the VRAM read in flight. Records whether the
//            read issued last cycle belongs to the line prefetch (and which
//            line-buffer slot it targets) or to the CPU, and steers the
//            returning mem_rdata to the line buffer or the CPU read port.
// Ports    : clk_pixel, rst_n           - clock, async active-low reset
//            issue_fetch, fetch_bank,
//            fetch_idx                  - prefetch read issued this cycle
//            issue_cpu_rd               - CPU read issued this cycle
//            mem_rdata                  - VRAM read data (1-cycle latency)
//            lb_we, lb_addr, lb_wdata   - line-buffer write port
//            cpu_rvalid, cpu_rdata      - CPU read return
// Revision : 1.0 - initial release
// ============================================================================
module vram_read_tracker
  import vram_line_scheduler_pkg::*;
#(
  parameter int DATA_W = c_default_data_w,
  parameter int LB_AW  = 8
) (
  input  logic              clk_pixel,
  input  logic              rst_n,
  input  logic              issue_fetch,
  input  logic              fetch_bank,
  input  logic [LB_AW-1:0]  fetch_idx,
  input  logic              issue_cpu_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [LB_AW:0]    lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata
);

  logic           r_fetch_pend;
  logic           r_cpu_pend;
  logic [LB_AW:0] r_lb_addr;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pend <= 1'b0;
      r_cpu_pend   <= 1'b0;
      r_lb_addr    <= '0;
    end else begin
      r_fetch_pend <= issue_fetch;
      r_cpu_pend   <= issue_cpu_rd;
      if (issue_fetch) begin
        r_lb_addr <= {fetch_bank, fetch_idx};
      end
    end
  end

  // Data ports are forced to zero when their tag is not set so that a CPU
  // read returning the cycle a fetch starts never reaches the line buffer.
  assign lb_we      = r_fetch_pend;
  assign lb_addr    = r_fetch_pend ? r_lb_addr : '0;
  assign lb_wdata   = r_fetch_pend ? mem_rdata : '0;
  assign cpu_rvalid = r_cpu_pend;
  assign cpu_rdata  = r_cpu_pend ? mem_rdata : '0;

endmodule : vram_read_tracker
`default_nettype wire

// File: rtl/vram_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vram_line_scheduler
// Purpose  : Owns the single-port VRAM. On each accepted line request it
//            bursts one line of words into the idle bank of a double-banked
//            line buffer, then flips the display bank. CPU reads/writes are
//            served whenever no prefetch is running.
// Ports    : clk_pixel, rst_n                    - clock, async active-low reset
//            line_req, line_num                  - prefetch request from timing
//            mem_en/we/addr/wdata, mem_rdata     - VRAM port
//            lb_we, lb_addr, lb_wdata, lb_rd_bank - line buffer port
//            cpu_valid/ready/we/addr/wdata,
//            cpu_rvalid, cpu_rdata               - CPU port
//            fetch_busy, underrun, underrun_clr  - status
// Revision : 1.0 - initial release
// ============================================================================
module vram_line_scheduler
  import vram_line_scheduler_pkg::*;
#(
  parameter int ADDR_W         = c_default_addr_w,
  parameter int DATA_W         = c_default_data_w,
  parameter int WORDS_PER_LINE = 160,
  parameter int LINE_STRIDE    = 160,
  parameter int LB_AW          = 8,
  parameter int V_VISIBLE      = c_v_visible
) (
  input  logic              clk_pixel,
  input  logic              rst_n,
  input  logic              line_req,
  input  logic [9:0]        line_num,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [LB_AW:0]    lb_addr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              lb_rd_bank,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              fetch_busy,
  output logic              underrun,
  input  logic              underrun_clr
);

  localparam logic [LB_AW-1:0] c_last_word = LB_AW'(WORDS_PER_LINE - 1);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ADDR_W-1:0] r_base;
  logic [LB_AW-1:0]  r_word_cnt;
  logic              r_fetch_bank;
  logic              r_lb_rd_bank;
  logic              r_underrun;

  logic              w_req_valid;
  logic              w_busy;
  logic              w_accept;
  logic [ADDR_W-1:0] w_base;
  logic              w_issue_fetch;
  logic              w_issue_cpu_rd;

  // Requests for lines outside the visible area are dropped everywhere.
  assign w_req_valid = line_req && (32'(line_num) < 32'(V_VISIBLE));
  assign w_busy      = (r_state != ST_IDLE);
  // rst_n gates acceptance so nothing leaves the block while held in reset.
  assign w_accept    = rst_n && (r_state == ST_IDLE) && w_req_valid;
  // Line base wraps modulo the VRAM address space.
  assign w_base      = ADDR_W'(32'(line_num) * 32'(LINE_STRIDE));

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      r_base       <= '0;
      r_word_cnt   <= '0;
      r_fetch_bank <= 1'b0;
      r_lb_rd_bank <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base       <= w_base;
        r_fetch_bank <= ~r_lb_rd_bank;
        r_word_cnt   <= '0;
      end else if (r_state == ST_FETCH) begin
        r_word_cnt <= r_word_cnt + LB_AW'(1);
      end

      // The display switches banks only once the final word has landed.
      if (r_state == ST_DRAIN) begin
        r_lb_rd_bank <= r_fetch_bank;
      end

      // A new request while busy means the display will miss a line;
      // setting takes priority over a simultaneous clear.
      if (w_busy && w_req_valid) begin
        r_underrun <= 1'b1;
      end else if (underrun_clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    mem_en         = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    cpu_ready      = 1'b0;
    w_issue_fetch  = 1'b0;
    w_issue_cpu_rd = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // The prefetch wins a same-cycle conflict with the CPU.
          w_state_next = ST_FETCH;
        end else if (rst_n) begin
          cpu_ready = 1'b1;
          if (cpu_valid) begin
            mem_en         = 1'b1;
            mem_we         = cpu_we;
            mem_addr       = cpu_addr;
            mem_wdata      = cpu_we ? cpu_wdata : '0;
            w_issue_cpu_rd = !cpu_we;
          end
        end
      end

      ST_FETCH: begin
        mem_en        = 1'b1;
        mem_addr      = r_base + ADDR_W'(r_word_cnt);
        w_issue_fetch = 1'b1;
        if (r_word_cnt == c_last_word) begin
          w_state_next = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  vram_read_tracker #(
    .DATA_W (DATA_W),
    .LB_AW  (LB_AW)
  ) u_read_tracker (
    .clk_pixel    (clk_pixel),
    .rst_n        (rst_n),
    .issue_fetch  (w_issue_fetch),
    .fetch_bank   (r_fetch_bank),
    .fetch_idx    (r_word_cnt),
    .issue_cpu_rd (w_issue_cpu_rd),
    .mem_rdata    (mem_rdata),
    .lb_we        (lb_we),
    .lb_addr      (lb_addr),
    .lb_wdata     (lb_wdata),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata)
  );

  assign lb_rd_bank = r_lb_rd_bank;
  assign fetch_busy = w_busy;
  assign underrun   = r_underrun;

endmodule : vram_line_scheduler
`default_nettype wire

// File: tb/tb_vram_line_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vram_line_scheduler
// Purpose  : Self-checking bench for vram_line_scheduler. A VRAM model with
//            pseudo-random initial contents answers reads; expected line
//            buffer traffic is computed from line_num*stride arithmetic and
//            a reference copy of all CPU writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_line_scheduler;

  localparam int WPL    = 160;
  localparam int STRIDE = 160;
  localparam int VVIS   = 480;

  logic        clk_pixel = 1'b0;
  logic        rst_n     = 1'b0;
  logic        line_req;
  logic [9:0]  line_num;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        lb_we;
  logic [8:0]  lb_addr;
  logic [15:0] lb_wdata;
  logic        lb_rd_bank;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        fetch_busy;
  logic        underrun;
  logic        underrun_clr;

  always #5 clk_pixel = ~clk_pixel;

  vram_line_scheduler dut (
    .clk_pixel    (clk_pixel),
    .rst_n        (rst_n),
    .line_req     (line_req),
    .line_num     (line_num),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .lb_we        (lb_we),
    .lb_addr      (lb_addr),
    .lb_wdata     (lb_wdata),
    .lb_rd_bank   (lb_rd_bank),
    .cpu_valid    (cpu_valid),
    .cpu_ready    (cpu_ready),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata),
    .fetch_busy   (fetch_busy),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] seed_mul;
  logic [15:0] seed_xor;
  logic [15:0] mem_wr [logic [15:0]];  // writes the DUT actually made
  logic [15:0] ref_wr [logic [15:0]];  // writes the bench expects
  int          wr1234 = 0;
  logic        m_rd_bank;
  logic        m_underrun;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    return (a * seed_mul) ^ seed_xor;
  endfunction

  function automatic logic [15:0] ref_word(input logic [15:0] a);
    if (ref_wr.exists(a)) return ref_wr[a];
    return init_word(a);
  endfunction

  // VRAM model: registered read, one-cycle latency; junk when not reading.
  always @(posedge clk_pixel) begin
    if (mem_en && !mem_we) begin
      mem_rdata <= mem_wr.exists(mem_addr) ? mem_wr[mem_addr] : init_word(mem_addr);
    end else begin
      mem_rdata <= 16'($urandom);
    end
    if (mem_en && mem_we) begin
      mem_wr[mem_addr] = mem_wdata;
      if (mem_addr == 16'h1234) wr1234 = wr1234 + 1;
    end
  end

  task automatic next_cycle();
    @(posedge clk_pixel);
    #1;
  endtask

  // Asserts reset asynchronously mid-cycle and checks every output is 0.
  task automatic do_reset();
    line_req = 1'b0; cpu_valid = 1'b0; underrun_clr = 1'b0;
    @(negedge clk_pixel);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata, lb_rd_bank,
         cpu_ready, cpu_rvalid, cpu_rdata, fetch_busy, underrun} !== 81'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {mem_en, mem_we, mem_addr, mem_wdata,
               lb_we, lb_addr, lb_wdata, lb_rd_bank, cpu_ready, cpu_rvalid, cpu_rdata,
               fetch_busy, underrun});
    end
    repeat (2) @(posedge clk_pixel);
    @(negedge clk_pixel);
    rst_n      = 1'b1;
    m_rd_bank  = 1'b0;
    m_underrun = 1'b0;
    next_cycle();
  endtask

  // Issues a line request and checks every cycle of the burst. Optionally
  // injects another request (inj_k) and/or underrun_clr (clr_k) at burst
  // cycle k. Returns at the falling edge of the first IDLE cycle afterwards.
  task automatic run_fetch(input int line, input int inj_k, input int inj_line,
                           input int clr_k, input bit exp_rv, input logic [15:0] exp_rd);
    logic [15:0] base;
    logic        bank;
    logic        old_bank;
    logic        e_men;
    logic        e_lbwe;
    logic [15:0] e_addr;
    logic [8:0]  e_lba;
    logic [15:0] e_lbd;
    logic [47:0] got;
    logic [47:0] exp;
    base     = 16'((line * STRIDE) % 65536);
    old_bank = m_rd_bank;
    bank     = ~m_rd_bank;
    line_req = 1'b1;
    line_num = 10'(line);
    @(negedge clk_pixel);
    checks++;
    if ({cpu_ready, fetch_busy, mem_en, lb_we, cpu_rvalid} !== {4'b0000, exp_rv}) begin
      errors++;
      $display("FAIL accept_cycle line=%0d got=%b exp=%b", line,
               {cpu_ready, fetch_busy, mem_en, lb_we, cpu_rvalid}, {4'b0000, exp_rv});
    end
    if (exp_rv) begin
      checks++;
      if (cpu_rdata !== exp_rd) begin
        errors++;
        $display("FAIL cpu_rdata_collision got=%h exp=%h", cpu_rdata, exp_rd);
      end
    end
    for (int k = 0; k <= WPL; k++) begin
      next_cycle();
      line_req     = (k == inj_k);
      line_num     = (k == inj_k) ? 10'(inj_line) : 10'(line);
      underrun_clr = (k == clr_k);
      @(negedge clk_pixel);
      e_men  = (k < WPL);
      e_lbwe = (k >= 1);
      e_addr = e_men ? base + 16'(k) : 16'h0;
      e_lba  = e_lbwe ? {bank, 8'(k - 1)} : 9'h0;
      e_lbd  = e_lbwe ? ref_word(base + 16'(k - 1)) : 16'h0;
      got = {mem_en, mem_we, (e_men ? mem_addr : 16'h0), lb_we, (e_lbwe ? lb_addr : 9'h0),
             (e_lbwe ? lb_wdata : 16'h0), cpu_ready, fetch_busy, lb_rd_bank, underrun};
      exp = {e_men, 1'b0, e_addr, e_lbwe, e_lba, e_lbd, 1'b0, 1'b1, old_bank, m_underrun};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL fetch_cycle line=%0d k=%0d got=%h exp=%h", line, k, got, exp);
      end
      if (k == inj_k && inj_line < VVIS) m_underrun = 1'b1;
      else if (k == clr_k) m_underrun = 1'b0;
    end
    next_cycle();
    line_req     = 1'b0;
    line_num     = 10'(line);
    underrun_clr = 1'b0;
    @(negedge clk_pixel);
    checks++;
    if ({fetch_busy, lb_rd_bank, lb_we, cpu_ready, underrun} !== {1'b0, bank, 1'b0, 1'b1, m_underrun}) begin
      errors++;
      $display("FAIL fetch_done line=%0d got=%b exp=%b", line,
               {fetch_busy, lb_rd_bank, lb_we, cpu_ready, underrun},
               {1'b0, bank, 1'b0, 1'b1, m_underrun});
    end
    m_rd_bank = bank;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_pixel);
    checks++;
    if ({cpu_ready, fetch_busy, underrun, lb_rd_bank, mem_en, lb_we, cpu_rvalid} !== 7'b1000000) begin
      errors++;
      $display("FAIL idle_after_reset got=%b exp=1000000",
               {cpu_ready, fetch_busy, underrun, lb_rd_bank, mem_en, lb_we, cpu_rvalid});
    end
    next_cycle();
  endtask

  task automatic test_fetch_line0();
    repeat (5) next_cycle();
    run_fetch(0, -1, 0, -1, 1'b0, 16'h0);
    next_cycle();
  endtask

  task automatic test_fetch_pair();
    do_reset();
    run_fetch(3, -1, 0, -1, 1'b0, 16'h0);  // base 480 into bank 1
    next_cycle();
    run_fetch(4, -1, 0, -1, 1'b0, 16'h0);  // base 640 into bank 0
    next_cycle();
  endtask

  task automatic test_random_fetches();
    int lines [6];
    lines[0] = 409;  // burst wraps past the top of the address space
    lines[1] = 479;  // last visible line
    for (int i = 2; i < 6; i++) lines[i] = int'($urandom_range(0, VVIS - 1));
    foreach (lines[i]) begin
      run_fetch(lines[i], -1, 0, -1, 1'b0, 16'h0);
      next_cycle();
    end
  endtask

  task automatic test_cpu_during_fetch();
    int          cnt0;
    logic [15:0] d;
    cnt0      = wr1234;
    d         = 16'($urandom);
    cpu_valid = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h1234;
    cpu_wdata = d;
    run_fetch(int'($urandom_range(0, VVIS - 1)), -1, 0, -1, 1'b0, 16'h0);
    checks++;
    if ({cpu_ready, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 16'h1234, d}) begin
      errors++;
      $display("FAIL cpu_write_after_fetch got=%h exp=%h",
               {cpu_ready, mem_en, mem_we, mem_addr, mem_wdata}, {3'b111, 16'h1234, d});
    end
    ref_wr[16'h1234] = d;
    next_cycle();
    cpu_valid = 1'b0;
    @(negedge clk_pixel);
    checks++;
    if (wr1234 - cnt0 !== 1) begin
      errors++;
      $display("FAIL cpu_write_count got=%0d exp=1", wr1234 - cnt0);
    end
    next_cycle();
    // Line 29 covers 0x1234: the fetched word must be the new value.
    run_fetch(29, -1, 0, -1, 1'b0, 16'h0);
    next_cycle();
  endtask

  task automatic test_cpu_read_collision();
    logic [15:0] exp_rd;
    int          line;
    cpu_valid = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0010;
    @(negedge clk_pixel);
    checks++;
    if ({cpu_ready, mem_en, mem_we, mem_addr} !== {3'b110, 16'h0010}) begin
      errors++;
      $display("FAIL cpu_read_issue got=%h exp=%h", {cpu_ready, mem_en, mem_we, mem_addr},
               {3'b110, 16'h0010});
    end
    exp_rd = ref_word(16'h0010);
    line   = int'($urandom_range(1, VVIS - 1));
    while (ref_word(16'((line * STRIDE) % 65536)) == exp_rd) line = (line % (VVIS - 1)) + 1;
    next_cycle();
    cpu_valid = 1'b0;
    run_fetch(line, -1, 0, -1, 1'b1, exp_rd);
    next_cycle();
  endtask

  task automatic test_cpu_random();
    bit          prev_rd;
    logic [15:0] prev_exp;
    logic [15:0] a;
    logic [15:0] d;
    bit          w;
    prev_rd  = 1'b0;
    prev_exp = 16'h0;
    for (int i = 0; i <= 24; i++) begin
      w = ($urandom_range(0, 1) == 1);
      a = 16'h2000 + 16'($urandom_range(0, 7));
      d = 16'($urandom);
      cpu_valid = (i < 24);
      cpu_we    = w;
      cpu_addr  = a;
      cpu_wdata = d;
      @(negedge clk_pixel);
      if (i < 24) begin
        checks++;
        if ({cpu_ready, mem_en, mem_we, mem_addr, (w ? mem_wdata : 16'h0)} !==
            {2'b11, w, a, (w ? d : 16'h0)}) begin
          errors++;
          $display("FAIL cpu_op i=%0d got=%h exp=%h", i,
                   {cpu_ready, mem_en, mem_we, mem_addr, (w ? mem_wdata : 16'h0)},
                   {2'b11, w, a, (w ? d : 16'h0)});
        end
      end
      checks++;
      if (cpu_rvalid !== prev_rd || (prev_rd && cpu_rdata !== prev_exp)) begin
        errors++;
        $display("FAIL cpu_rdata i=%0d got=%b/%h exp=%b/%h", i, cpu_rvalid, cpu_rdata,
                 prev_rd, prev_exp);
      end
      prev_rd = (i < 24) && !w;
      if (i < 24 && w) ref_wr[a] = d;
      else if (i < 24) prev_exp = ref_word(a);
      next_cycle();
    end
    cpu_valid = 1'b0;
  endtask

  task automatic test_underrun();
    run_fetch(int'($urandom_range(0, VVIS - 1)), 20, int'($urandom_range(0, VVIS - 1)), -1,
              1'b0, 16'h0);
    next_cycle();
    // Set and clear in the same DRAIN cycle: set wins.
    run_fetch(int'($urandom_range(0, VVIS - 1)), WPL, int'($urandom_range(0, VVIS - 1)), WPL,
              1'b0, 16'h0);
    next_cycle();
    underrun_clr = 1'b1;
    next_cycle();
    underrun_clr = 1'b0;
    m_underrun   = 1'b0;
    @(negedge clk_pixel);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear got=%b exp=0", underrun);
    end
    next_cycle();
    // An out-of-range request during a fetch is not an underrun.
    run_fetch(int'($urandom_range(0, VVIS - 1)), 50, int'($urandom_range(VVIS, 1023)), -1,
              1'b0, 16'h0);
    next_cycle();
  endtask

  task automatic test_ignore();
    int nums [2];
    nums[0] = VVIS;
    nums[1] = 1023;
    foreach (nums[i]) begin
      line_req = 1'b1;
      line_num = 10'(nums[i]);
      @(negedge clk_pixel);
      checks++;
      if ({cpu_ready, fetch_busy, mem_en} !== 3'b100) begin
        errors++;
        $display("FAIL ignore_req line=%0d got=%b exp=100", nums[i], {cpu_ready, fetch_busy, mem_en});
      end
      next_cycle();
      line_req = 1'b0;
      @(negedge clk_pixel);
      checks++;
      if ({fetch_busy, mem_en, underrun, lb_rd_bank} !== {2'b00, m_underrun, m_rd_bank}) begin
        errors++;
        $display("FAIL ignore_after line=%0d got=%b exp=%b", nums[i],
                 {fetch_busy, mem_en, underrun, lb_rd_bank}, {2'b00, m_underrun, m_rd_bank});
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_fetch();
    int          line;
    logic [15:0] base;
    line     = int'($urandom_range(0, VVIS - 1));
    base     = 16'((line * STRIDE) % 65536);
    line_req = 1'b1;
    line_num = 10'(line);
    next_cycle();
    line_req = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      next_cycle();
      line_req = (k == 10);
    end
    checks++;
    if ({mem_en, mem_addr, underrun} !== {1'b1, base + 16'd50, 1'b1}) begin
      errors++;
      $display("FAIL mid_fetch_word50 got=%h exp=%h", {mem_en, mem_addr, underrun},
               {1'b1, base + 16'd50, 1'b1});
    end
    do_reset();
    run_fetch(int'($urandom_range(0, VVIS - 1)), -1, 0, -1, 1'b0, 16'h0);
    next_cycle();
  endtask

  initial begin
    seed_mul     = 16'($urandom) | 16'h0001;
    seed_xor     = 16'($urandom);
    line_req     = 1'b0;
    line_num     = 10'h0;
    cpu_valid    = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr     = 16'h0;
    cpu_wdata    = 16'h0;
    underrun_clr = 1'b0;
    m_rd_bank    = 1'b0;
    m_underrun   = 1'b0;

    test_reset();
    test_fetch_line0();
    test_fetch_pair();
    test_random_fetches();
    test_cpu_during_fetch();
    test_cpu_read_collision();
    test_cpu_random();
    test_underrun();
    test_ignore();
    test_reset_mid_fetch();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vram_line_scheduler
`default_nettype wire

// File: doc/vram_line_scheduler.md
Name: vram_line_scheduler

Overview:
- Owns the single-port video RAM and shares it between two requesters: the scan-out path (line prefetch) and a CPU-side writer/reader.
- Each horizontal blanking interval, the VGA timing block pulses a line request. The scheduler then bursts one line of pixel words from VRAM into a double-banked line buffer.
- CPU accesses are served whenever no prefetch is in progress.
- Sits between the VGA timing generator, the VRAM macro and the pixel line buffer.

Parameters:
- ADDR_W, 16, VRAM word-address width.
- DATA_W, 16, VRAM / line-buffer word width.
- WORDS_PER_LINE, 160, words fetched per line (640 px at 4 bpp).
- LINE_STRIDE, 160, VRAM words between consecutive line bases.
- LB_AW, 8, line-buffer address width per bank (2^LB_AW must be >= WORDS_PER_LINE).
- V_VISIBLE, 480, count of visible lines; line requests at or above this are ignored.

Ports:
- clk_pixel  in  1  pixel clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- line_req  in  1  one-cycle pulse: prefetch line line_num.
- line_num  in  10  line index to fetch.
- mem_en  out  1  VRAM access strobe.
- mem_we  out  1  VRAM write enable.
- mem_addr  out  ADDR_W  VRAM address.
- mem_wdata  out  DATA_W  VRAM write data.
- mem_rdata  in  DATA_W  VRAM read data, valid exactly 1 cycle after a read strobe.
- lb_we  out  1  line-buffer write enable.
- lb_addr  out  LB_AW+1  {bank, word index}.
- lb_wdata  out  DATA_W  line-buffer write data.
- lb_rd_bank  out  1  bank the display side must read (last completed fetch).
- cpu_valid  in  1  CPU request valid.
- cpu_ready  out  1  CPU request accepted this cycle when cpu_valid is also high.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rvalid  out  1  read data valid pulse.
- cpu_rdata  out  DATA_W  read data.
- fetch_busy  out  1  high in FETCH or DRAIN.
- underrun  out  1  sticky: a line request arrived while a fetch was busy.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - State goes to IDLE.
  - All outputs are 0, including lb_rd_bank and the fetch bank pointer.
  - Word counter is 0; pending-read tracking is cleared.
- States:
  - IDLE: serve CPU.
  - FETCH: issue reads.
  - DRAIN: one cycle for the last read data to arrive; then go to IDLE.
- Request acceptance in IDLE:
  - A line_req with line_num < V_VISIBLE is accepted.
  - On acceptance: latch base = line_num*LINE_STRIDE, truncated mod 2^ADDR_W; set fetch bank = ~lb_rd_bank; go to FETCH.
  - A line_req with line_num >= V_VISIBLE is ignored in every state and never sets underrun.
- FETCH:
  - Each cycle: mem_en=1, mem_we=0, mem_addr = base + k, where k = 0..WORDS_PER_LINE-1 (address wraps mod 2^ADDR_W).
  - After issuing k = WORDS_PER_LINE-1, go to DRAIN.
- Line-buffer writes:
  - Read data for word k arrives one cycle after its issue.
  - On that cycle: lb_we=1, lb_addr = {fetch bank, k}, lb_wdata = mem_rdata.
  - The write for the final word occurs in the DRAIN cycle.
- Completion: at the end of DRAIN, lb_rd_bank <= fetch bank and fetch_busy drops.
- Prefetch latency: line_req at cycle t gives the first mem_en at t+1 and the last lb_we at t+WORDS_PER_LINE+1.
- CPU handshake:
  - cpu_ready = (state == IDLE) && !(accepted line_req this cycle). The fetch wins a simultaneous conflict.
  - Write accepted: mem_en=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata in the same cycle.
  - Read accepted: mem_en=1, mem_we=0; cpu_rvalid=1 with cpu_rdata=mem_rdata on the next cycle.
  - A line_req may be accepted on that next cycle; the returning CPU read data must not be written to the line buffer.
  - cpu_ready is 0 throughout FETCH and DRAIN; the CPU holds its request until accepted.
- Underrun:
  - A valid line_req during FETCH or DRAIN is dropped; the current fetch continues unchanged; underrun <= 1.
  - underrun_clr clears it. If set and clear occur in the same cycle, set wins.
- Outputs mem_*/lb_* are combinational from registered state plus current inputs. No combinational path from mem_rdata to mem_*.

Decomposition:
- Shared video package holds:
  - V_VISIBLE and the H/V timing constants.
  - The state enum {IDLE, FETCH, DRAIN}.
  - Default ADDR_W and DATA_W.
- One natural sub-module: vram_read_tracker. It is a one-deep pipeline tag recording whether the in-flight read belongs to the fetch (with its line-buffer index) or the CPU, and it routes mem_rdata accordingly.

Test Plan:
- Fetch line 0 after reset: line_req=1, line_num=0 at cycle 10.
  - mem_addr 0..159 on cycles 11..170.
  - lb_we at cycles 12..171 with lb_addr {1,0..159}.
  - lb_rd_bank=1 after cycle 171; fetch_busy low at 172.
- Fetch line 3 then line 4:
  - First base is 480; the second fetch writes bank 0 at base 640; lb_rd_bank toggles 1 then 0.
- CPU during fetch:
  - cpu_valid write to 0x1234 held during a fetch keeps cpu_ready=0.
  - The write is accepted the first IDLE cycle; the VRAM model shows 0x1234 written once.
- CPU read / line_req collision:
  - CPU read of 0x0010 is accepted; line_req arrives the next cycle.
  - cpu_rvalid returns model data; the first line-buffer write is the fetch word, not the CPU data.
- Underrun and ignore:
  - line_req during FETCH sets underrun, the fetch completes unchanged, and underrun_clr clears it.
  - A line_req with line_num=480 does nothing.
- Reset mid-fetch:
  - rst_n low at word 50: all outputs are 0 immediately and lb_rd_bank=0.
  - A new line_req after release fetches bank 1 from word 0.
